// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, key-length codes and the byte-level
// transforms reused by the encipher and the future decipher.
package aes_pkg;

    localparam int AES_BLK_W      = 128;
    localparam int AES_MAX_ROUNDS = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ROUND = 2'b01,
        S_DONE  = 2'b10
    } aes_state_e;

    typedef enum logic [1:0] {
        KEY_128 = 2'b00,
        KEY_192 = 2'b01,
        KEY_256 = 2'b10,
        KEY_RSV = 2'b11
    } keylen_e;

    // The reserved code falls back to the AES-128 round count.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (keylen_e'(kl))
            KEY_192: return 4'd12;
            KEY_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gm2(a0) ^ gm3(a1) ^ a2 ^ a3,
                a0 ^ gm2(a1) ^ gm3(a2) ^ a3,
                a0 ^ a1 ^ gm2(a2) ^ gm3(a3),
                gm3(a0) ^ a1 ^ a2 ^ gm2(a3)};
    endfunction

    function automatic logic [AES_BLK_W-1:0] mixcolumns(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] r;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = mixw(s[127-32*c -: 32]);
        return r;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [AES_BLK_W-1:0] shiftrows(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] r;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox_128.sv
// Sixteen parallel combinational AES S-box lookups over a full 128-bit state.
module aes_sbox_128
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] i_state,
    output logic [AES_BLK_W-1:0] o_state
);

    // Table is written S(0) first, so entry S(x) lives at packed index 255-x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar g = 0; g < 16; g++) begin : g_byte
        assign o_state[8*g +: 8] = SBOX[8'd255 - i_state[8*g +: 8]];
    end

endmodule

// File: rtl/aes_iter_encipher.sv
// Iterative AES-128/192/256 encipher: one round per cycle over a flop-based
// round-key memory loaded by an external key-schedule unit.
module aes_iter_encipher
    import aes_pkg::*;
#(
    parameter int MAX_ROUNDS = AES_MAX_ROUNDS,
    parameter int BLK_W      = AES_BLK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_keylen,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [BLK_W-1:0] i_in_block,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [BLK_W-1:0] o_out_block,
    input  logic             i_rk_we,
    input  logic [3:0]       i_rk_addr,
    input  logic [BLK_W-1:0] i_rk_data,
    output logic             o_rk_err,
    input  logic             i_abort,
    output logic             o_busy
);

    localparam logic [3:0] LAST_ADDR = 4'(MAX_ROUNDS);

    aes_state_e       r_state;
    aes_state_e       w_next;
    logic [3:0]       r_round;
    logic [3:0]       r_nr;
    logic [BLK_W-1:0] r_blk;
    logic [BLK_W-1:0] r_out_block;
    logic [BLK_W-1:0] r_rk [0:MAX_ROUNDS];
    logic             r_rk_err;
    logic [BLK_W-1:0] w_sub;
    logic [BLK_W-1:0] w_sr;
    logic [BLK_W-1:0] w_mc;
    logic [BLK_W-1:0] w_rk;
    logic             w_accept;
    logic             w_last;
    logic             w_rk_ok;

    aes_sbox_128 u_sbox (
        .i_state (r_blk),
        .o_state (w_sub)
    );

    assign w_sr     = shiftrows(w_sub);
    assign w_mc     = mixcolumns(w_sr);
    assign w_rk     = r_rk[r_round];
    assign w_last   = (r_round == r_nr);
    assign w_accept = o_in_ready && i_in_valid;
    assign w_rk_ok  = (r_state == S_IDLE) && (i_rk_addr <= LAST_ADDR);

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_in_valid)  w_next = S_ROUND;
                S_ROUND: if (w_last)      w_next = S_DONE;
                S_DONE:  if (i_out_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE:  o_in_ready = !i_abort;
            S_ROUND: o_busy     = 1'b1;
            S_DONE: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Round 0 is the bare key whitening; the final round skips MixColumns and
    // lands directly in the output register so the state can be reloaded early.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_blk       <= '0;
            r_out_block <= '0;
            r_round     <= 4'd0;
            r_nr        <= 4'd10;
        end else if (w_accept) begin
            r_blk   <= i_in_block;
            r_nr    <= nr_of(i_keylen);
            r_round <= 4'd0;
        end else if (r_state == S_ROUND && !i_abort) begin
            r_round <= w_last ? r_round : r_round + 4'd1;
            if (r_round == 4'd0)
                r_blk <= r_blk ^ w_rk;
            else if (w_last)
                r_out_block <= w_sr ^ w_rk;
            else
                r_blk <= w_mc ^ w_rk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && i_rk_we && w_rk_ok)
            r_rk[i_rk_addr] <= i_rk_data;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_rk_err <= 1'b0;
        else
            r_rk_err <= i_rk_we && !w_rk_ok;
    end

    assign o_out_block = r_out_block;
    assign o_rk_err    = r_rk_err;

endmodule

// File: tb/tb_aes_iter_encipher.sv
// Scoreboard bench for aes_iter_encipher: FIPS-197 vectors, control corner
// cases and randomized keys/blocks against a byte-level AES model.
module tb_aes_iter_encipher;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   keylen;
    logic         inValid;
    logic         inReady;
    logic [127:0] inBlock;
    logic         outValid;
    logic         outReady;
    logic [127:0] outBlock;
    logic         rkWe;
    logic [3:0]   rkAddr;
    logic [127:0] rkData;
    logic         rkErr;
    logic         abort;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cycleCnt = 0;
    bit randReady = 0;
    int lastAccept = 0;

    typedef struct {
        logic [127:0] blk;
        int           acc;
        int           nr;
    } expT;
    expT sbQ[$];

    logic [7:0]   sbTab   [256];
    logic [127:0] modelRk [0:14];

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_iter_encipher dut (
        .clk         (clk),
        .rst         (rst),
        .i_keylen    (keylen),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_in_block  (inBlock),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_block (outBlock),
        .i_rk_we     (rkWe),
        .i_rk_addr   (rkAddr),
        .i_rk_data   (rkData),
        .o_rk_err    (rkErr),
        .i_abort     (abort),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse plus the affine map.
    task automatic buildSbox;
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbTab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] x);
        return {sbTab[x[31:24]], sbTab[x[23:16]], sbTab[x[15:8]], sbTab[x[7:0]]};
    endfunction

    task automatic keyExpand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nr;
        nr = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            modelRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] modelEncrypt(input logic [127:0] pt, input int nr);
        logic [7:0] st [16];
        logic [7:0] tmp [16];
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [127:0] res;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ modelRk[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) tmp[i] = sbTab[st[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    st[row+4*c] = tmp[row+4*((c+row)%4)];
            if (r < nr) begin
                for (int i = 0; i < 16; i++) tmp[i] = st[i];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++)
                            acc = acc ^ gmul(coef[(k-row+4)%4], tmp[k+4*c]);
                        st[row+4*c] = acc;
                    end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ modelRk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (randReady) outReady = ($urandom_range(0, 3) != 0);
    endtask

    task automatic loadKeys(input logic [255:0] key, input int nk);
        keyExpand(key, nk);
        for (int r = 0; r <= nk + 6; r++) begin
            rkWe = 1'b1; rkAddr = 4'(r); rkData = modelRk[r];
            tick;
        end
        rkWe = 1'b0;
    endtask

    task automatic applyStimulus(input logic [127:0] pt, input logic [1:0] kl,
                                 input logic [127:0] expBlk, input int nr,
                                 input bit key0, input bit doPush);
        int guard = 0;
        while (!inReady && guard < 200) begin tick; guard++; end
        checkOutput("inReadyWait", {127'h0, inReady}, 128'h1);
        inValid = 1'b1; inBlock = pt; keylen = kl;
        if (key0) begin rkWe = 1'b1; rkAddr = 4'd0; rkData = modelRk[0]; end
        tick;
        inValid = 1'b0; rkWe = 1'b0;
        keylen = 2'($urandom_range(0, 3));
        lastAccept = cycleCnt;
        if (doPush) sbQ.push_back('{expBlk, cycleCnt, nr});
    endtask

    task automatic waitDrained;
        int guard = 0;
        while ((sbQ.size() != 0 || busy) && guard < 500) begin tick; guard++; end
        checkOutput("drain", {127'h0, (sbQ.size() == 0 && !busy)}, 128'h1);
    endtask

    task automatic monitorLoop;
        expT e;
        logic [127:0] heldBlk = '0;
        bit holding = 0;
        forever begin
            @(negedge clk);
            if (outValid) begin
                if (!holding) begin
                    if (sbQ.size() == 0) begin
                        total++; bad++;
                        $display("[TB] FAIL unexpectedOut: got %h, want no output", outBlock);
                    end else begin
                        e = sbQ.pop_front();
                        checkOutput("cipher", outBlock, e.blk);
                        checkOutput("latency", 128'(cycleCnt - e.acc), 128'(e.nr + 1));
                    end
                    heldBlk = outBlock;
                    holding = 1;
                end else begin
                    checkOutput("holdStable", outBlock, heldBlk);
                end
                if (outReady) holding = 0;
            end else begin
                holding = 0;
            end
        end
    endtask

    initial begin
        int acc1;
        int nk;
        int guard;
        logic [255:0] rkey;
        logic [127:0] pt;
        logic [1:0]   kl;

        rst = 1'b0; keylen = 2'b00; inValid = 1'b0; inBlock = '0;
        outReady = 1'b1; rkWe = 1'b0; rkAddr = 4'd0; rkData = '0; abort = 1'b0;
        buildSbox;
        fork monitorLoop; join_none

        repeat (3) tick;
        checkOutput("rstOutValid", {127'h0, outValid}, 128'h0);
        checkOutput("rstOutBlock", outBlock, 128'h0);
        checkOutput("rstRkErr", {127'h0, rkErr}, 128'h0);
        checkOutput("rstBusy", {127'h0, busy}, 128'h0);
        rst = 1'b1;
        tick;
        checkOutput("rstInReady", {127'h0, inReady}, 128'h1);

        // AES-128 with a long output stall.
        loadKeys(FIPS_KEY, 4);
        outReady = 1'b0;
        applyStimulus(FIPS_PT, 2'b00, C1, 10, 0, 1);
        guard = 0;
        while (!outValid && guard < 50) begin tick; guard++; end
        checkOutput("validSeen", {127'h0, outValid}, 128'h1);
        repeat (20) begin
            checkOutput("bpInReady", {127'h0, inReady}, 128'h0);
            tick;
        end
        outReady = 1'b1;
        tick;
        checkOutput("bpRelease", {127'h0, outValid}, 128'h0);
        checkOutput("bpInReadyAfter", {127'h0, inReady}, 128'h1);

        // Back-to-back blocks, illegal write while rounds are running.
        applyStimulus(FIPS_PT, 2'b00, C1, 10, 0, 1);
        acc1 = lastAccept;
        tick; tick;
        rkWe = 1'b1; rkAddr = 4'd3; rkData = {4{$urandom}};
        tick;
        rkWe = 1'b0;
        checkOutput("rkErrRound", {127'h0, rkErr}, 128'h1);
        tick;
        checkOutput("rkErrPulse", {127'h0, rkErr}, 128'h0);
        applyStimulus(FIPS_PT, 2'b00, C1, 10, 0, 1);
        checkOutput("b2bRate", 128'(lastAccept - acc1), 128'd13);
        waitDrained;

        rkWe = 1'b1; rkAddr = 4'd15; rkData = {4{$urandom}};
        tick;
        rkWe = 1'b0;
        checkOutput("rkErrAddr", {127'h0, rkErr}, 128'h1);
        tick;
        checkOutput("rkErrAddrPulse", {127'h0, rkErr}, 128'h0);

        // rk[0] corrupted, then rewritten in the very accept cycle.
        rkWe = 1'b1; rkAddr = 4'd0; rkData = ~modelRk[0];
        tick;
        rkWe = 1'b0;
        applyStimulus(FIPS_PT, 2'b00, C1, 10, 1, 1);
        waitDrained;

        abort = 1'b1; inValid = 1'b1; inBlock = FIPS_PT;
        #1;
        checkOutput("abortGatesReady", {127'h0, inReady}, 128'h0);
        tick;
        abort = 1'b0; inValid = 1'b0;
        checkOutput("abortNoAccept", {127'h0, busy}, 128'h0);

        applyStimulus(FIPS_PT, 2'b00, C1, 10, 0, 0);
        repeat (5) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checkOutput("abortBusy", {127'h0, busy}, 128'h0);
        checkOutput("abortOutValid", {127'h0, outValid}, 128'h0);

        applyStimulus(FIPS_PT, 2'b00, C1, 10, 0, 0);
        repeat (4) tick;
        rst = 1'b0;
        tick;
        checkOutput("midRstBusy", {127'h0, busy}, 128'h0);
        checkOutput("midRstOutValid", {127'h0, outValid}, 128'h0);
        rst = 1'b1;
        tick;
        checkOutput("midRstInReady", {127'h0, inReady}, 128'h1);
        applyStimulus(FIPS_PT, 2'b00, C1, 10, 0, 1);
        waitDrained;

        loadKeys(FIPS_KEY, 6);
        applyStimulus(FIPS_PT, 2'b01, C2, 12, 0, 1);
        waitDrained;
        loadKeys(FIPS_KEY, 8);
        applyStimulus(FIPS_PT, 2'b10, C3, 14, 0, 1);
        waitDrained;

        // Random keys, blocks and output backpressure.
        randReady = 1;
        for (int s = 0; s < 3; s++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            nk = 4 + 2 * $urandom_range(0, 2);
            waitDrained;
            loadKeys(rkey, nk);
            for (int b = 0; b < 5; b++) begin
                pt = {$urandom, $urandom, $urandom, $urandom};
                if (nk == 4) kl = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                else kl = (nk == 6) ? 2'b01 : 2'b10;
                applyStimulus(pt, kl, modelEncrypt(pt, nk + 6), nk + 6, 0, 1);
            end
        end
        waitDrained;
        randReady = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
